// File: rtl/pc_predict_reg_pkg.sv
// Shared constants for the fetch PC / branch target buffer slice.
package pc_predict_reg_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Default stall-vector bit positions
  localparam int STALL_FREEZE_IDX_DEF = 1;
  localparam int STALL_HOLD_IDX_DEF   = 0;

  // 2-bit saturating direction counter; bit 1 set means predict taken
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } btb_ctr_e;

  function automatic btb_ctr_e ctr_inc(input btb_ctr_e c);
    case (c)
      STRONG_NT: return WEAK_NT;
      WEAK_NT:   return WEAK_T;
      default:   return STRONG_T;
    endcase
  endfunction

  function automatic btb_ctr_e ctr_dec(input btb_ctr_e c);
    case (c)
      STRONG_T: return WEAK_T;
      WEAK_T:   return WEAK_NT;
      default:  return STRONG_NT;
    endcase
  endfunction

endpackage

// File: rtl/pc_predict_reg_if.sv
// Fetch-side bus: EX drives stall/redirect/update, fetch PC block returns pc and prediction.
interface pc_predict_reg_if #(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 5
) ();

  logic [STALL_W-1:0] stall;
  logic               jumpEnable;
  logic [ADDR_W-1:0]  jumpAddress;
  logic               upd_en;
  logic [ADDR_W-1:0]  upd_pc;
  logic [ADDR_W-1:0]  upd_target;
  logic               upd_taken;
  logic [ADDR_W-1:0]  pc;
  logic               jump;
  logic               pred_taken;
  logic [ADDR_W-1:0]  pred_target;

  modport master (
    output stall, jumpEnable, jumpAddress,
    output upd_en, upd_pc, upd_target, upd_taken,
    input  pc, jump, pred_taken, pred_target
  );

  modport slave (
    input  stall, jumpEnable, jumpAddress,
    input  upd_en, upd_pc, upd_target, upd_taken,
    output pc, jump, pred_taken, pred_target
  );

endinterface

// File: rtl/pc_predict_reg_btb.sv
// Direct-mapped branch target buffer: async lookup on the fetch PC,
// synchronous update/allocate from resolved branches in EX.
module pc_btb
  import pc_predict_reg_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BTB_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_lookup_pc,
  output logic              o_pred_taken,
  output logic [ADDR_W-1:0] o_pred_target,
  input  logic              i_upd_en,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic [ADDR_W-1:0] i_upd_target,
  input  logic              i_upd_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic              r_valid  [BTB_ENTRIES];
  logic [TAG_W-1:0]  r_tag    [BTB_ENTRIES];
  logic [ADDR_W-1:0] r_target [BTB_ENTRIES];
  btb_ctr_e          r_ctr    [BTB_ENTRIES];

  logic [IDX_W-1:0]  w_lk_idx;
  logic [TAG_W-1:0]  w_lk_tag;
  logic              w_lk_hit;
  logic [IDX_W-1:0]  w_up_idx;
  logic [TAG_W-1:0]  w_up_tag;
  logic              w_up_hit;
  logic [ADDR_W-1:0] w_up_target;
  logic              w_unused_lsbs;

  assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag = i_lookup_pc[ADDR_W-1:IDX_W+2];
  assign w_up_idx = i_upd_pc[IDX_W+1:2];
  assign w_up_tag = i_upd_pc[ADDR_W-1:IDX_W+2];

  // Byte offsets never reach the array; targets are stored word aligned
  assign w_unused_lsbs = ^{i_lookup_pc[1:0], i_upd_pc[1:0], i_upd_target[1:0]};
  assign w_up_target   = {i_upd_target[ADDR_W-1:2], 2'b00};

  // Lookup reads current array contents, so a same-cycle write is seen next cycle
  always_comb begin
    w_lk_hit      = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    o_pred_taken  = w_lk_hit && r_ctr[w_lk_idx][1];
    o_pred_target = w_lk_hit ? r_target[w_lk_idx] : '0;
  end

  assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

  // Clear on reset; otherwise train the counter or allocate on a taken miss
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WEAK_NT;
      end
    end else if (i_upd_en) begin
      if (w_up_hit) begin
        if (i_upd_taken) begin
          r_ctr[w_up_idx]    <= ctr_inc(r_ctr[w_up_idx]);
          r_target[w_up_idx] <= w_up_target;
        end else begin
          r_ctr[w_up_idx]    <= ctr_dec(r_ctr[w_up_idx]);
        end
      end else if (i_upd_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= w_up_tag;
        r_target[w_up_idx] <= w_up_target;
        r_ctr[w_up_idx]    <= WEAK_T;
      end
    end
  end

endmodule

// File: rtl/pc_predict_reg.sv
// Fetch PC register with stall/redirect priority and BTB-driven prediction.
module pc_predict_reg
  import pc_predict_reg_pkg::*;
#(
  parameter int                ADDR_W           = 32,
  parameter logic [ADDR_W-1:0] RESET_PC         = '0,
  parameter int                STALL_W          = 5,
  parameter int                STALL_FREEZE_IDX = STALL_FREEZE_IDX_DEF,
  parameter int                STALL_HOLD_IDX   = STALL_HOLD_IDX_DEF,
  parameter int                BTB_ENTRIES      = 16
) (
  input logic              clk,
  input logic              rst,
  pc_predict_reg_if.slave  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_jump;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_jump_next;
  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic              w_unused_jmp_lsbs;

  assign w_unused_jmp_lsbs = ^bus.jumpAddress[1:0];

  pc_btb #(
    .ADDR_W      (ADDR_W),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .i_lookup_pc   (r_pc),
    .o_pred_taken  (w_pred_taken),
    .o_pred_target (w_pred_target),
    .i_upd_en      (bus.upd_en),
    .i_upd_pc      (bus.upd_pc),
    .i_upd_target  (bus.upd_target),
    .i_upd_taken   (bus.upd_taken)
  );

  // Next-PC priority: freeze, redirect, hold, predicted-taken, sequential
  always_comb begin
    w_pc_next   = r_pc;
    w_jump_next = r_jump;
    if (bus.stall[STALL_FREEZE_IDX]) begin
      w_pc_next   = r_pc;
      w_jump_next = r_jump;
    end else if (bus.jumpEnable) begin
      w_pc_next   = {bus.jumpAddress[ADDR_W-1:2], 2'b00};
      w_jump_next = 1'b1;
    end else if (bus.stall[STALL_HOLD_IDX]) begin
      w_pc_next   = r_pc;
      w_jump_next = r_jump;
    end else if (w_pred_taken) begin
      w_pc_next   = w_pred_target;
      w_jump_next = 1'b0;
    end else begin
      w_pc_next   = r_pc + ADDR_W'(4);
      w_jump_next = 1'b0;
    end
  end

  // PC and redirect flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc   <= RESET_PC;
      r_jump <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_jump <= w_jump_next;
    end
  end

  assign bus.pc          = r_pc;
  assign bus.jump        = r_jump;
  assign bus.pred_taken  = w_pred_taken;
  assign bus.pred_target = w_pred_target;

endmodule

// File: tb/tb_pc_predict_reg.sv
// Directed bench for pc_predict_reg with an expectation queue.
module tb_pc_predict_reg;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_predict_reg_if #(.ADDR_W(32), .STALL_W(5)) bus ();

  pc_predict_reg #(
    .ADDR_W           (32),
    .RESET_PC         (32'h0),
    .STALL_W          (5),
    .STALL_FREEZE_IDX (1),
    .STALL_HOLD_IDX   (0),
    .BTB_ENTRIES      (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        jump;
    logic        pt;
    logic [31:0] ptg;
    string       name;
  } exp_t;

  exp_t sb[$];

  task automatic drive(input logic [4:0] st, input logic je, input logic [31:0] ja,
                       input logic ue, input logic [31:0] up, input logic [31:0] ut,
                       input logic uk);
    bus.stall       = st;
    bus.jumpEnable  = je;
    bus.jumpAddress = ja;
    bus.upd_en      = ue;
    bus.upd_pc      = up;
    bus.upd_target  = ut;
    bus.upd_taken   = uk;
  endtask

  task automatic check_front();
    exp_t e;
    e = sb.pop_front();
    checks += 4;
    assert (bus.pc === e.pc) else begin
      failures++;
      $error("FAIL %s_pc observed=%h expected=%h", e.name, bus.pc, e.pc);
    end
    assert (bus.jump === e.jump) else begin
      failures++;
      $error("FAIL %s_jump observed=%b expected=%b", e.name, bus.jump, e.jump);
    end
    assert (bus.pred_taken === e.pt) else begin
      failures++;
      $error("FAIL %s_pred_taken observed=%b expected=%b", e.name, bus.pred_taken, e.pt);
    end
    assert (bus.pred_target === e.ptg) else begin
      failures++;
      $error("FAIL %s_pred_target observed=%h expected=%h", e.name, bus.pred_target, e.ptg);
    end
  endtask

  // Push the expected post-edge state, clock once, compare on the falling edge
  task automatic cyc(input logic [31:0] pc, input logic j, input logic pt,
                     input logic [31:0] ptg, input string name);
    exp_t e;
    e.pc = pc; e.jump = j; e.pt = pt; e.ptg = ptg; e.name = name;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    check_front();
  endtask

  initial begin
    rst = 1'b1;
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h0, 0, 0, 0, "reset");
    rst = 1'b0;
    cyc(32'h4, 0, 0, 0, "free1");
    cyc(32'h8, 0, 0, 0, "free2");
    cyc(32'hC, 0, 0, 0, "free3");

    drive(5'b0, 1, 32'h103, 0, 0, 0, 0);
    cyc(32'h100, 1, 0, 0, "redir");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h104, 0, 0, 0, "redir_next");

    drive(5'b00010, 1, 32'h200, 0, 0, 0, 0);
    cyc(32'h104, 0, 0, 0, "freeze1");
    cyc(32'h104, 0, 0, 0, "freeze2");
    drive(5'b0, 1, 32'h200, 0, 0, 0, 0);
    cyc(32'h200, 1, 0, 0, "freeze_rel");
    drive(5'b00001, 1, 32'h300, 0, 0, 0, 0);
    cyc(32'h300, 1, 0, 0, "hold_redir");
    drive(5'b00001, 0, 0, 0, 0, 0, 0);
    cyc(32'h300, 1, 0, 0, "hold_keep");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h304, 0, 0, 0, "hold_rel");

    drive(5'b0, 0, 0, 1, 32'h20, 32'h80, 1);
    cyc(32'h308, 0, 0, 0, "alloc20");
    drive(5'b0, 1, 32'h18, 0, 0, 0, 0);
    cyc(32'h18, 1, 0, 0, "to18");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h1C, 0, 0, 0, "seq1c");
    cyc(32'h20, 0, 1, 32'h80, "at20_pred");
    cyc(32'h80, 0, 0, 0, "pred_follow");

    drive(5'b0, 0, 0, 1, 32'h20, 32'h0, 0);
    cyc(32'h84, 0, 0, 0, "nt1");
    cyc(32'h88, 0, 0, 0, "nt2");
    drive(5'b0, 1, 32'h20, 0, 0, 0, 0);
    cyc(32'h20, 1, 0, 32'h80, "at20_weak");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h24, 0, 0, 0, "seq_after20");

    drive(5'b0, 0, 0, 1, 32'h20, 32'h40, 1);
    cyc(32'h28, 0, 0, 0, "upd20_again");
    drive(5'b0, 0, 0, 1, 32'h60, 32'h90, 1);
    cyc(32'h2C, 0, 0, 0, "alias60");
    drive(5'b0, 1, 32'h60, 0, 0, 0, 0);
    cyc(32'h60, 1, 1, 32'h90, "at60_pred");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h90, 0, 0, 0, "follow60");
    drive(5'b0, 1, 32'h20, 0, 0, 0, 0);
    cyc(32'h20, 1, 0, 0, "at20_evicted");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h24, 0, 0, 0, "seq24");

    drive(5'b0, 0, 0, 1, 32'h24, 32'h103, 1);
    cyc(32'h28, 0, 0, 0, "collide");
    drive(5'b0, 1, 32'h24, 0, 0, 0, 0);
    cyc(32'h24, 1, 1, 32'h100, "at24_pred");
    drive(5'b00001, 0, 0, 0, 0, 0, 0);
    cyc(32'h24, 1, 1, 32'h100, "hold_pred");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h100, 0, 0, 0, "follow24");

    drive(5'b0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    cyc(32'hFFFF_FFFC, 1, 0, 0, "top_addr");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h0, 0, 0, 0, "wrap");

    cyc(32'h4, 0, 0, 0, "pre_rst");
    rst = 1'b1;
    drive(5'b0, 1, 32'h400, 1, 32'h24, 32'h200, 1);
    cyc(32'h0, 0, 0, 0, "rst_override");
    rst = 1'b0;
    drive(5'b0, 1, 32'h24, 0, 0, 0, 0);
    cyc(32'h24, 1, 0, 0, "btb_cleared");
    drive(5'b0, 1, 32'h60, 0, 0, 0, 0);
    cyc(32'h60, 1, 0, 0, "btb_cleared60");
    drive(5'b0, 0, 0, 0, 0, 0, 0);
    cyc(32'h64, 0, 0, 0, "final_seq");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
